mem_wb: RTL and testbench
=========================

Name: mem_wb

Overview:
- MEM/WB pipeline register and writeback stage of the 5-stage MIPS core.
- Takes the MEM-stage result and load op, and aligns and sign/zero-extends load data.
- Registers the result under stall/flush control and drives the regfile write port directly (wb_wreg→we, wb_wd→waddr, wb_wdata→wdata).
- Latency from MEM inputs to WB outputs is 1 clock.

Parameters:
DATA_W, 32, register/data width (matches RegBus)
ADDR_W, 5, register address width (matches RegAddrBus)

Ports:
clk  input  1  core clock
rst  input  1  synchronous, active-high reset
stall  input  6  pipeline stall vector; bit4 = MEM stalled, bit5 = WB stalled
flush  input  1  exception flush, kills the entry being captured
mem_wreg  input  1  MEM instruction writes a GPR
mem_wd  input  ADDR_W  destination GPR
mem_wdata  input  DATA_W  ALU/MEM result for non-loads
mem_load_op  input  3  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW; 6–7 treated as NONE
mem_addr_lo  input  2  byte offset of the load address
mem_rdata  input  DATA_W  raw big-endian memory word
wb_wreg  output  1  regfile write enable
wb_wd  output  ADDR_W  regfile write address
wb_wdata  output  DATA_W  regfile write data
wb_misalign  output  1  one-cycle flag: misaligned load was suppressed

Behaviour:
- Reset: clk and rst are one clock domain with synchronous active-high reset. On a posedge with rst=1, all outputs go to 0.
- Update priority at each posedge, highest first:
  1. rst=1 or flush=1 → bubble.
  2. stall[4]=1 and stall[5]=0 → bubble (MEM held, WB advances with nothing).
  3. stall[4]=0 → capture the aligned result.
  4. Otherwise (both stalled) → hold all outputs unchanged.
- Bubble: wb_wreg=0, wb_wd=0, wb_wdata=0, wb_misalign=0.
- Load alignment (combinational, before the register), big-endian; byte k = bits [31-8k : 24-8k]:
  - LB/LBU: select byte mem_addr_lo; sign-extend (LB) or zero-extend (LBU) to 32 bits.
  - LH/LHU: mem_addr_lo[1]=0 selects [31:16], =1 selects [15:0]; extend as above.
  - LW: mem_rdata unchanged.
  - NONE: mem_wdata unchanged.
- Misalignment:
  - Misaligned cases: LH/LHU with mem_addr_lo[0]=1, or LW with mem_addr_lo≠0.
  - On capture: wb_wreg=0, wb_wdata=0, wb_misalign=1.
  - wb_misalign lasts exactly one cycle unless held by a double stall.
- Captured mem_wreg=1 with mem_wd=0 passes through unchanged; the regfile discards writes to $0.
- Same-cycle read-after-write forwarding is done by the regfile, not here.
- Flush asserted together with a capture condition: flush wins and the entry is lost.

Optional Feature:
HILO_EN
- Defined:
  - Adds inputs mem_whilo (1), mem_hi (DATA_W), mem_lo (DATA_W).
  - Adds outputs wb_whilo, wb_hi, wb_lo.
  - These follow the same bubble/capture/hold rules; bubble value 0.
  - wb_whilo feeds the HI/LO register.
- Undefined: these ports and flops are absent; all other behaviour is identical.

Decomposition:
- Shared defines include (defines.v): RegBus, RegAddrBus, ZeroWord, RstEnable, WriteEnable, the LOAD_* opcode constants, and the stall bit indices.
- One natural combinational sub-module, load_align: (load_op, addr_lo, rdata, wdata) → (data, misalign). mem_wb instantiates it and holds the flops plus stall/flush logic.

Test Plan:
- Reset then idle: rst=1 for 2 clk → all outputs 0. Release with stall=0, mem_wreg=1, wd=5, wdata=0x1234, load NONE → next clk wb_wreg=1, wb_wd=5, wb_wdata=0x00001234.
- LB sign: mem_rdata=0x12F45678, addr_lo=1, LB → wb_wdata=0xFFFFFFF4; same with LBU → 0x000000F4; LHU addr_lo=2 → 0x00005678.
- Misalign: LW addr_lo=2, mem_wreg=1 → wb_wreg=0, wb_misalign=1 for one cycle; next capture of an aligned op clears it.
- Stall bubble: stall=6'b010000 with a valid MEM op → WB shows bubble. stall=6'b110000 → outputs hold previous value for every stalled cycle.
- Flush priority: flush=1 with stall=0 and a valid LW → bubble; the following cycle captures normally.
- HILO_EN build: mem_whilo=1, hi=0xA, lo=0xB → wb_whilo=1, wb_hi=0xA, wb_lo=0xB next clk; stall[4]=1, stall[5]=0 → wb_whilo=0.

Source files
------------

// File: rtl/mem_wb_pkg.sv
// mem_wb shared types: load opcodes, stall bit indices, widths.
// Optional HI/LO writeback path is enabled by defining HILO_EN.
package mem_wb_pkg;

    localparam int REG_W      = 32;
    localparam int REG_ADDR_W = 5;

    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    typedef enum logic [2:0] {
        LOAD_NONE = 3'd0,
        LOAD_LB   = 3'd1,
        LOAD_LBU  = 3'd2,
        LOAD_LH   = 3'd3,
        LOAD_LHU  = 3'd4,
        LOAD_LW   = 3'd5
    } load_op_e;

endpackage

// File: rtl/mem_wb_if.sv
// MEM->WB bundle: MEM-side result/load inputs and WB regfile write port.
// Extra HI/LO signals exist only when HILO_EN is defined.
interface mem_wb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              mem_wreg;
    logic [ADDR_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem_wdata;
    logic [2:0]        mem_load_op;
    logic [1:0]        mem_addr_lo;
    logic [DATA_W-1:0] mem_rdata;

    logic              wb_wreg;
    logic [ADDR_W-1:0] wb_wd;
    logic [DATA_W-1:0] wb_wdata;
    logic              wb_misalign;
`ifdef HILO_EN
    logic              mem_whilo;
    logic [DATA_W-1:0] mem_hi;
    logic [DATA_W-1:0] mem_lo;
    logic              wb_whilo;
    logic [DATA_W-1:0] wb_hi;
    logic [DATA_W-1:0] wb_lo;
`endif

    modport master (
        output mem_wreg, mem_wd, mem_wdata,
        output mem_load_op, mem_addr_lo, mem_rdata,
`ifdef HILO_EN
        output mem_whilo, mem_hi, mem_lo,
        input  wb_whilo, wb_hi, wb_lo,
`endif
        input  wb_wreg, wb_wd, wb_wdata, wb_misalign
    );

    modport slave (
        input  mem_wreg, mem_wd, mem_wdata,
        input  mem_load_op, mem_addr_lo, mem_rdata,
`ifdef HILO_EN
        input  mem_whilo, mem_hi, mem_lo,
        output wb_whilo, wb_hi, wb_lo,
`endif
        output wb_wreg, wb_wd, wb_wdata, wb_misalign
    );

endinterface

// File: rtl/mem_wb_load_align.sv
// Big-endian load data alignment with sign/zero extension.
// Flags halfword/word loads whose address is not naturally aligned.
module mem_wb_load_align
    import mem_wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        load_op,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] rdata,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] data,
    output logic              misalign
);

    logic [DATA_W-1:0] shifted;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic              is_b;
    logic              is_h;
    logic              is_w;
    logic              sx;

    // Byte 0 is the most significant; shift it down to bits [7:0].
    assign shifted  = rdata >> {~addr_lo, 3'b000};
    assign byte_sel = shifted[7:0];
    assign half_sel = addr_lo[1] ? rdata[15:0] : rdata[DATA_W-1 -: 16];

    assign is_b = (load_op == LOAD_LB) || (load_op == LOAD_LBU);
    assign is_h = (load_op == LOAD_LH) || (load_op == LOAD_LHU);
    assign is_w = (load_op == LOAD_LW);
    assign sx   = (load_op == LOAD_LB) || (load_op == LOAD_LH);

    always_comb begin
        data     = wdata;
        misalign = 1'b0;
        unique case (1'b1)
            is_b: data = {{(DATA_W-8){sx & byte_sel[7]}}, byte_sel};
            is_h: begin
                data     = {{(DATA_W-16){sx & half_sel[15]}}, half_sel};
                misalign = addr_lo[0];
            end
            is_w: begin
                data     = rdata;
                misalign = (addr_lo != 2'b00);
            end
            default: data = wdata;
        endcase
    end

endmodule

// File: rtl/mem_wb.sv
// MEM/WB pipeline register and writeback stage with stall/flush control.
// Define HILO_EN to also carry the HI/LO write through this stage.
module mem_wb
    import mem_wb_pkg::*;
#(
    parameter int DATA_W = REG_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] stall,
    input  logic       flush,
    mem_wb_if.slave    bus
);

    logic [DATA_W-1:0] al_data;
    logic              al_mis;
    logic              bubble;
    logic              capture;

    mem_wb_load_align #(.DATA_W(DATA_W)) u_align (
        .load_op  (bus.mem_load_op),
        .addr_lo  (bus.mem_addr_lo),
        .rdata    (bus.mem_rdata),
        .wdata    (bus.mem_wdata),
        .data     (al_data),
        .misalign (al_mis)
    );

    // MEM held while WB runs on: WB must see an empty slot.
    assign bubble  = rst | flush |
                     (stall[STALL_MEM] & ~stall[STALL_WB]);
    assign capture = ~stall[STALL_MEM];

    always_ff @(posedge clk) begin
        if (bubble) begin
            bus.wb_wreg     <= 1'b0;
            bus.wb_wd       <= '0;
            bus.wb_wdata    <= '0;
            bus.wb_misalign <= 1'b0;
        end else if (capture) begin
            bus.wb_wreg     <= bus.mem_wreg & ~al_mis;
            bus.wb_wd       <= bus.mem_wd;
            bus.wb_wdata    <= al_mis ? '0 : al_data;
            bus.wb_misalign <= al_mis;
        end
    end

`ifdef HILO_EN
    always_ff @(posedge clk) begin
        if (bubble) begin
            bus.wb_whilo <= 1'b0;
            bus.wb_hi    <= '0;
            bus.wb_lo    <= '0;
        end else if (capture) begin
            bus.wb_whilo <= bus.mem_whilo;
            bus.wb_hi    <= bus.mem_hi;
            bus.wb_lo    <= bus.mem_lo;
        end
    end
`endif

endmodule

// File: tb/tb_mem_wb.sv
// Directed testbench for mem_wb: reset, load alignment, misalign,
// stall bubble/hold, flush priority and (with HILO_EN) HI/LO path.
module tb_mem_wb;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] stall;
    logic       flush;
    int         checks = 0;
    int         failures = 0;

    mem_wb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    mem_wb #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .stall (stall),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wreg, input logic [4:0] wd,
                         input logic [31:0] wdata, input logic [2:0] op,
                         input logic [1:0] lo, input logic [31:0] rdata);
        bus.mem_wreg    = wreg;
        bus.mem_wd      = wd;
        bus.mem_wdata   = wdata;
        bus.mem_load_op = op;
        bus.mem_addr_lo = lo;
        bus.mem_rdata   = rdata;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = '0; flush = 1'b0;
        drive(1'b1, 5'd9, 32'hDEADBEEF, 3'd0, 2'd0, 32'h0);
        tick(); tick();
        checks++;
        if (bus.wb_wreg !== 1'b0 || bus.wb_wd !== 5'd0 ||
            bus.wb_wdata !== 32'h0 || bus.wb_misalign !== 1'b0) begin
            failures++;
            $display("FAIL reset got wreg=%b wd=%0d wdata=%h mis=%b exp all 0",
                     bus.wb_wreg, bus.wb_wd, bus.wb_wdata, bus.wb_misalign);
        end
        rst = 1'b0;
        drive(1'b1, 5'd5, 32'h1234, 3'd0, 2'd0, 32'hFFFFFFFF);
        tick();
        checks++;
        if (bus.wb_wreg !== 1'b1 || bus.wb_wd !== 5'd5 ||
            bus.wb_wdata !== 32'h00001234 || bus.wb_misalign !== 1'b0) begin
            failures++;
            $display("FAIL idle_pass got wreg=%b wd=%0d wdata=%h mis=%b exp 1 5 00001234 0",
                     bus.wb_wreg, bus.wb_wd, bus.wb_wdata, bus.wb_misalign);
        end
    endtask

    task automatic test_load_ext();
        logic [2:0]  ops [8]  = '{3'd1, 3'd2, 3'd4, 3'd3, 3'd3, 3'd5, 3'd6, 3'd1};
        logic [1:0]  los [8]  = '{2'd1, 2'd1, 2'd2, 2'd0, 2'd2, 2'd0, 2'd3, 2'd3};
        logic [31:0] rds [8]  = '{32'h12F45678, 32'h12F45678, 32'h12F45678,
                                  32'h12F45678, 32'h0000C001, 32'hCAFEF00D,
                                  32'h11111111, 32'hAABBCC80};
        logic [31:0] exps [8] = '{32'hFFFFFFF4, 32'h000000F4, 32'h00005678,
                                  32'h000012F4, 32'hFFFFC001, 32'hCAFEF00D,
                                  32'h0BADF00D, 32'hFFFFFF80};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 5'd7, 32'h0BADF00D, ops[i], los[i], rds[i]);
            tick();
            checks++;
            if (bus.wb_wdata !== exps[i] || bus.wb_wreg !== 1'b1 ||
                bus.wb_misalign !== 1'b0) begin
                failures++;
                $display("FAIL load_ext[%0d] got wdata=%h wreg=%b mis=%b exp %h 1 0",
                         i, bus.wb_wdata, bus.wb_wreg, bus.wb_misalign, exps[i]);
            end
        end
    endtask

    task automatic test_misalign();
        drive(1'b1, 5'd3, 32'h55, 3'd5, 2'd2, 32'h89ABCDEF);
        tick();
        checks++;
        if (bus.wb_wreg !== 1'b0 || bus.wb_misalign !== 1'b1 ||
            bus.wb_wdata !== 32'h0 || bus.wb_wd !== 5'd3) begin
            failures++;
            $display("FAIL misalign_lw got wreg=%b mis=%b wdata=%h wd=%0d exp 0 1 0 3",
                     bus.wb_wreg, bus.wb_misalign, bus.wb_wdata, bus.wb_wd);
        end
        drive(1'b1, 5'd3, 32'h55, 3'd5, 2'd0, 32'h89ABCDEF);
        tick();
        checks++;
        if (bus.wb_wreg !== 1'b1 || bus.wb_misalign !== 1'b0 ||
            bus.wb_wdata !== 32'h89ABCDEF) begin
            failures++;
            $display("FAIL misalign_clear got wreg=%b mis=%b wdata=%h exp 1 0 89abcdef",
                     bus.wb_wreg, bus.wb_misalign, bus.wb_wdata);
        end
        drive(1'b1, 5'd4, 32'h55, 3'd4, 2'd3, 32'h89ABCDEF);
        tick();
        checks++;
        if (bus.wb_wreg !== 1'b0 || bus.wb_misalign !== 1'b1 ||
            bus.wb_wdata !== 32'h0) begin
            failures++;
            $display("FAIL misalign_lhu got wreg=%b mis=%b wdata=%h exp 0 1 0",
                     bus.wb_wreg, bus.wb_misalign, bus.wb_wdata);
        end
        drive(1'b1, 5'd0, 32'h77, 3'd0, 2'd1, 32'h0);
        tick();
        checks++;
        if (bus.wb_misalign !== 1'b0 || bus.wb_wreg !== 1'b1 ||
            bus.wb_wd !== 5'd0 || bus.wb_wdata !== 32'h77) begin
            failures++;
            $display("FAIL misalign_onecycle got mis=%b wreg=%b wd=%0d wdata=%h exp 0 1 0 77",
                     bus.wb_misalign, bus.wb_wreg, bus.wb_wd, bus.wb_wdata);
        end
    endtask

    task automatic test_stall();
        stall = 6'b010000;
        drive(1'b1, 5'd12, 32'hABCD, 3'd0, 2'd0, 32'h0);
        tick();
        checks++;
        if (bus.wb_wreg !== 1'b0 || bus.wb_wd !== 5'd0 ||
            bus.wb_wdata !== 32'h0 || bus.wb_misalign !== 1'b0) begin
            failures++;
            $display("FAIL stall_bubble got wreg=%b wd=%0d wdata=%h mis=%b exp all 0",
                     bus.wb_wreg, bus.wb_wd, bus.wb_wdata, bus.wb_misalign);
        end
        stall = 6'b000000;
        drive(1'b1, 5'd21, 32'h0, 3'd3, 2'd2, 32'h00008765);
        tick();
        checks++;
        if (bus.wb_wdata !== 32'hFFFF8765 || bus.wb_wd !== 5'd21) begin
            failures++;
            $display("FAIL stall_pre got wdata=%h wd=%0d exp ffff8765 21",
                     bus.wb_wdata, bus.wb_wd);
        end
        stall = 6'b110000;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 5'(i + 1), 32'(i), 3'd5, 2'd1, 32'h0);
            tick();
            checks++;
            if (bus.wb_wreg !== 1'b1 || bus.wb_wd !== 5'd21 ||
                bus.wb_wdata !== 32'hFFFF8765 || bus.wb_misalign !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold[%0d] got wreg=%b wd=%0d wdata=%h mis=%b exp 1 21 ffff8765 0",
                         i, bus.wb_wreg, bus.wb_wd, bus.wb_wdata, bus.wb_misalign);
            end
        end
        stall = 6'b000000;
        drive(1'b1, 5'd2, 32'h0, 3'd5, 2'd1, 32'h0);
        tick();
        stall = 6'b110000;
        tick(); tick();
        checks++;
        if (bus.wb_misalign !== 1'b1 || bus.wb_wreg !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold_mis got mis=%b wreg=%b exp 1 0",
                     bus.wb_misalign, bus.wb_wreg);
        end
        stall = 6'b000000;
    endtask

    task automatic test_flush();
        flush = 1'b1;
        drive(1'b1, 5'd8, 32'h0, 3'd5, 2'd0, 32'h13579BDF);
        tick();
        checks++;
        if (bus.wb_wreg !== 1'b0 || bus.wb_wd !== 5'd0 ||
            bus.wb_wdata !== 32'h0 || bus.wb_misalign !== 1'b0) begin
            failures++;
            $display("FAIL flush_bubble got wreg=%b wd=%0d wdata=%h mis=%b exp all 0",
                     bus.wb_wreg, bus.wb_wd, bus.wb_wdata, bus.wb_misalign);
        end
        flush = 1'b0;
        tick();
        checks++;
        if (bus.wb_wreg !== 1'b1 || bus.wb_wd !== 5'd8 ||
            bus.wb_wdata !== 32'h13579BDF) begin
            failures++;
            $display("FAIL flush_after got wreg=%b wd=%0d wdata=%h exp 1 8 13579bdf",
                     bus.wb_wreg, bus.wb_wd, bus.wb_wdata);
        end
        flush = 1'b1;
        stall = 6'b110000;
        tick();
        checks++;
        if (bus.wb_wreg !== 1'b0 || bus.wb_wdata !== 32'h0) begin
            failures++;
            $display("FAIL flush_over_hold got wreg=%b wdata=%h exp 0 0",
                     bus.wb_wreg, bus.wb_wdata);
        end
        flush = 1'b0;
        stall = 6'b000000;
    endtask

`ifdef HILO_EN
    task automatic test_hilo();
        bus.mem_whilo = 1'b1;
        bus.mem_hi    = 32'hA;
        bus.mem_lo    = 32'hB;
        tick();
        checks++;
        if (bus.wb_whilo !== 1'b1 || bus.wb_hi !== 32'hA || bus.wb_lo !== 32'hB) begin
            failures++;
            $display("FAIL hilo_cap got whilo=%b hi=%h lo=%h exp 1 a b",
                     bus.wb_whilo, bus.wb_hi, bus.wb_lo);
        end
        stall = 6'b010000;
        tick();
        checks++;
        if (bus.wb_whilo !== 1'b0 || bus.wb_hi !== 32'h0 || bus.wb_lo !== 32'h0) begin
            failures++;
            $display("FAIL hilo_bubble got whilo=%b hi=%h lo=%h exp 0 0 0",
                     bus.wb_whilo, bus.wb_hi, bus.wb_lo);
        end
        stall = 6'b000000;
        bus.mem_whilo = 1'b0;
    endtask
`endif

    initial begin
`ifdef HILO_EN
        bus.mem_whilo = 1'b0;
        bus.mem_hi    = '0;
        bus.mem_lo    = '0;
`endif
        test_reset();
        test_load_ext();
        test_misalign();
        test_stall();
        test_flush();
`ifdef HILO_EN
        test_hilo();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
